// File: rtl/tp_ram_burst_reader.sv
// Burst read client for a synchronous two-port RAM.
// It takes a (base, length) command and drives the RAM read port. A tag pipe tracks
// the fixed read latency of the RAM. Returned words pass through a small skid FIFO and
// leave as a valid/ready stream that marks the final word of the burst with OutLast.
// A read is issued only when the FIFO is certain to have room for its data. Under this
// credit limit the FIFO cannot overflow, however long the sink applies backpressure.
module tp_ram_burst_reader #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_DEPTH  = 1024,
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 1,
  parameter int BUF_DEPTH   = 4,
  parameter int LEN_WIDTH   = 11
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  Start_SI,
  input  logic                  Abort_SI,
  input  logic [ADDR_WIDTH-1:0] BaseAddr_DI,
  input  logic [LEN_WIDTH-1:0]  Len_DI,
  output logic                  Busy_SO,
  output logic                  Done_SO,
  output logic                  RdEn_SO,
  output logic [ADDR_WIDTH-1:0] RdAddr_DO,
  input  logic [DATA_WIDTH-1:0] RdData_DI,
  output logic                  OutValid_SO,
  input  logic                  OutReady_SI,
  output logic [DATA_WIDTH-1:0] OutData_DO,
  output logic                  OutLast_SO
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  // Parameter combinations that cannot work are rejected at elaboration.
  if (BUF_DEPTH < RAM_LATENCY + 1) begin : g_bad_buf_depth
    $error("BUF_DEPTH must be at least RAM_LATENCY+1");
  end
  if (RAM_LATENCY < 1) begin : g_bad_latency
    $error("RAM_LATENCY must be at least 1");
  end
  if (DATA_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("DATA_DEPTH must not exceed 2**ADDR_WIDTH");
  end

  logic [1:0]             state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   left_q;
  logic                   done_q;
  logic [RAM_LATENCY-1:0] tag_vld_q;
  logic [RAM_LATENCY-1:0] tag_last_q;
  logic [DATA_WIDTH:0]    buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       cnt_q;

  logic                   active;
  logic                   abort_hit;
  logic                   out_valid;
  logic                   pop;
  logic                   push;
  logic                   credit_ok;
  logic                   rd_en;
  logic                   last_issue;
  logic [31:0]            inflight;
  logic [ADDR_WIDTH-1:0]  addr_nxt;
  logic [DATA_WIDTH:0]    head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign active     = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign abort_hit  = active && Abort_SI;
  assign inflight   = $countones(tag_vld_q);
  assign out_valid  = (cnt_q != '0);
  assign pop        = out_valid && OutReady_SI;
  // Data whose tag leaves the pipe during an abort or a flush is dropped.
  assign push       = tag_vld_q[RAM_LATENCY-1] && active && !Abort_SI;
  // A word popped this cycle already frees its slot for the read issued now.
  assign credit_ok  = (inflight + 32'(cnt_q)) < (32'(BUF_DEPTH) + 32'(pop));
  assign rd_en      = (state_q == ST_ISSUE) && !Abort_SI && credit_ok;
  assign last_issue = (left_q == LEN_WIDTH'(1));
  assign addr_nxt   = (addr_q == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : addr_q + 1'b1;
  assign head       = buf_mem[rd_ptr_q];

  assign Busy_SO     = (state_q != ST_IDLE);
  assign Done_SO     = done_q;
  assign RdEn_SO     = rd_en;
  assign RdAddr_DO   = addr_q;
  assign OutValid_SO = out_valid;
  // Gating the outputs with valid keeps them at zero while the FIFO is empty. It also
  // means the FIFO storage never needs a reset value.
  assign OutData_DO  = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign OutLast_SO  = out_valid && head[DATA_WIDTH];

  // Burst control: the state sequence, the read address and the count of reads still to issue.
  // NOTE: every clocked block uses non-blocking assignments, so all state updates
  // take effect together at the clock edge, whatever order the statements are written in.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (Start_SI) begin
            if (Len_DI != '0) begin
              state_q <= ST_ISSUE;
              addr_q  <= BaseAddr_DI;
              left_q  <= Len_DI;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (Abort_SI) begin
            state_q <= ST_FLUSH;
          end else if (rd_en) begin
            addr_q <= addr_nxt;
            left_q <= left_q - 1'b1;
            if (last_issue) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (Abort_SI) begin
            state_q <= ST_FLUSH;
          end else if (pop && head[DATA_WIDTH]) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (inflight == 32'd0) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Tag pipe: holds one valid bit and one last-word flag for each read still in the RAM.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      tag_vld_q  <= '0;
      tag_last_q <= '0;
    end else begin
      tag_vld_q[0]  <= rd_en;
      tag_last_q[0] <= last_issue;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
    end
  end

  // Skid FIFO pointers and occupancy; an abort empties the FIFO at once.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (abort_hit) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Skid FIFO storage: each entry holds a returned word and its last-word flag.
  // NOTE: the storage has no reset. Reset clears the occupancy count, so stale
  // entries are never visible, and leaving the array unreset lets it map onto plain RAM cells.
  always_ff @(posedge Clk_CI) begin
    if (push) buf_mem[wr_ptr_q] <= {tag_last_q[RAM_LATENCY-1], RdData_DI};
  end

endmodule
